spike_scheduler: RTL and testbench
==================================

SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

Interface
REQ-001 SHALL have parameter N, default 256, number of neurons.
REQ-002 SHALL have parameter M, default 8, neuron address width (log2 N).
REQ-003 SHALL have parameter DEPTH, default 16, number of FIFO entries (power of two, ≥2).
REQ-004 SHALL have port CLK, input, 1, single clock, all state updates on its rising edge.
REQ-005 SHALL have port RSTN_syncn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port SPI_GATE_ACTIVITY_sync, input, 1, network gated for SPI access; synchronous flush.
REQ-007 SHALL have port CTRL_NEURMEM_CS, input, 1, neuron memory chip select.
REQ-008 SHALL have port CTRL_NEURMEM_WE, input, 1, neuron memory write enable.
REQ-009 SHALL have port CTRL_NEURMEM_ADDR, input, M, address of the neuron being written back.
REQ-010 SHALL have port NEUR_EVENT_OUT, input, 7, neuron core output: [6] spike flag, [5:3] reserved and ignored, [2:0] burst length minus one.
REQ-011 SHALL have port CTRL_SCHED_POP, input, 1, controller consumes the current head event.
REQ-012 SHALL have port SCHED_EMPTY, output, 1, FIFO holds no entry.
REQ-013 SHALL have port SCHED_FULL, output, 1, FIFO holds DEPTH entries.
REQ-014 SHALL have port SCHED_DATA_OUT, output, M, source neuron address of the head entry.
REQ-015 SHALL have port SCHED_BURST_END, output, 1, current replica is the last one of the head burst.
REQ-016 SHALL have port SCHED_COUNT, output, log2(DEPTH)+1, number of stored entries.
REQ-017 SHALL have port SCHED_OVERFLOW, output, 1, sticky flag: an event was dropped.

Function
REQ-018 Push condition SHALL be CTRL_NEURMEM_CS & CTRL_NEURMEM_WE & NEUR_EVENT_OUT[6] & !SPI_GATE_ACTIVITY_sync.
REQ-019 A push SHALL store {NEUR_EVENT_OUT[2:0], CTRL_NEURMEM_ADDR} at the write pointer; the write pointer advances modulo DEPTH.
REQ-020 A pushed entry into an empty FIFO SHALL appear on SCHED_DATA_OUT, with SCHED_EMPTY low, in the cycle after the push edge (1-cycle latency).
REQ-021 The block SHALL hold a 3-bit replica counter rcnt for the head entry, cleared on reset, on flush, and on each dequeue.
REQ-022 SCHED_BURST_END SHALL be combinational: !SCHED_EMPTY & (rcnt == head burst field).
REQ-023 CTRL_SCHED_POP with FIFO non-empty and SCHED_BURST_END low SHALL increment rcnt only; the head stays.
REQ-024 CTRL_SCHED_POP with SCHED_BURST_END high SHALL dequeue the head: read pointer advances modulo DEPTH; rcnt returns to 0.
REQ-025 Each stored event SHALL therefore be presented burst+1 times (1..8) before removal.
REQ-026 CTRL_SCHED_POP while SCHED_EMPTY SHALL be ignored, with no pointer, count or rcnt change.
REQ-027 A push while full SHALL be accepted only if a dequeue occurs in the same cycle; otherwise the event is dropped and SCHED_OVERFLOW is set.
REQ-028 A simultaneous push and dequeue SHALL leave SCHED_COUNT unchanged; push-only adds 1; dequeue-only subtracts 1.
REQ-029 SCHED_FULL SHALL equal (SCHED_COUNT == DEPTH), and SCHED_EMPTY SHALL equal (SCHED_COUNT == 0).
REQ-030 SCHED_COUNT SHALL never exceed DEPTH or underflow below 0.
REQ-031 SPI_GATE_ACTIVITY_sync high SHALL, on the next edge, clear both pointers, SCHED_COUNT, rcnt and SCHED_OVERFLOW.
REQ-032 Pushes and pops SHALL be ignored while SPI_GATE_ACTIVITY_sync is high.
REQ-033 SCHED_DATA_OUT SHALL be 0 whenever SCHED_EMPTY is high.

Reset
REQ-034 RSTN_syncn low SHALL immediately, without waiting for a clock edge, force pointers, SCHED_COUNT, rcnt and SCHED_OVERFLOW to 0.
REQ-035 While RSTN_syncn is low, outputs SHALL be SCHED_EMPTY=1, SCHED_FULL=0, SCHED_DATA_OUT=0, SCHED_BURST_END=0 and SCHED_COUNT=0.
REQ-036 FIFO storage contents need not be reset.
REQ-037 Reset asserted mid-burst SHALL discard all entries; the first post-reset push is presented with rcnt=0.

Verification
REQ-038 Push addr 0x2A with burst 0 and no pop: after 1 cycle SCHED_DATA_OUT=0x2A, SCHED_BURST_END=1, COUNT=1; one pop then gives EMPTY=1.
REQ-039 Push addr 0x05 with burst 3, then pop 4 times: SCHED_BURST_END=0,0,0,1 across the 4 pops; EMPTY=1 after the 4th.
REQ-040 Push 16 events (addr 0..15) with no pops, then a 17th (addr 0x99): FULL=1, OVERFLOW=1, COUNT=16; drain yields 0..15 in order with 0x99 absent.
REQ-041 With FIFO full and head at burst end, push and pop in the same cycle: COUNT stays 16, OVERFLOW stays 0, the new entry drains last.
REQ-042 Load 5 entries, raise SPI_GATE_ACTIVITY_sync for 1 cycle while also pushing: COUNT=0, EMPTY=1, OVERFLOW=0, no entry stored.
REQ-043 Assert RSTN_syncn low between clock edges mid-burst (rcnt=2): outputs go to reset values before the next edge; the next push presents rcnt=0.

Source files
------------

// File: rtl/spike_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_scheduler_if
// Description : Bundle of the spike scheduler's controller-facing signals.
//               The master modport is the neuron core / controller side that
//               writes events and consumes them; the slave modport is the
//               scheduler FIFO itself.
// Ports       : SPI_GATE_ACTIVITY_sync  - synchronous flush / activity gate
//               CTRL_NEURMEM_CS/WE      - neuron memory write-back strobes
//               CTRL_NEURMEM_ADDR[M]    - neuron address being written back
//               NEUR_EVENT_OUT[7]       - [6] spike, [5:3] rsvd, [2:0] burst-1
//               CTRL_SCHED_POP          - consume one replica of the head
//               SCHED_EMPTY/FULL        - occupancy flags
//               SCHED_DATA_OUT[M]       - head source address (0 when empty)
//               SCHED_BURST_END         - current replica is the last one
//               SCHED_COUNT             - number of stored entries
//               SCHED_OVERFLOW          - sticky "event dropped" flag
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_scheduler_if #(
  parameter int M     = 8,
  parameter int DEPTH = 16
) ();

  logic                     SPI_GATE_ACTIVITY_sync;
  logic                     CTRL_NEURMEM_CS;
  logic                     CTRL_NEURMEM_WE;
  logic [M-1:0]             CTRL_NEURMEM_ADDR;
  logic [6:0]               NEUR_EVENT_OUT;
  logic                     CTRL_SCHED_POP;
  logic                     SCHED_EMPTY;
  logic                     SCHED_FULL;
  logic [M-1:0]             SCHED_DATA_OUT;
  logic                     SCHED_BURST_END;
  logic [$clog2(DEPTH):0]   SCHED_COUNT;
  logic                     SCHED_OVERFLOW;

  modport master (
    output SPI_GATE_ACTIVITY_sync,
    output CTRL_NEURMEM_CS,
    output CTRL_NEURMEM_WE,
    output CTRL_NEURMEM_ADDR,
    output NEUR_EVENT_OUT,
    output CTRL_SCHED_POP,
    input  SCHED_EMPTY,
    input  SCHED_FULL,
    input  SCHED_DATA_OUT,
    input  SCHED_BURST_END,
    input  SCHED_COUNT,
    input  SCHED_OVERFLOW
  );

  modport slave (
    input  SPI_GATE_ACTIVITY_sync,
    input  CTRL_NEURMEM_CS,
    input  CTRL_NEURMEM_WE,
    input  CTRL_NEURMEM_ADDR,
    input  NEUR_EVENT_OUT,
    input  CTRL_SCHED_POP,
    output SCHED_EMPTY,
    output SCHED_FULL,
    output SCHED_DATA_OUT,
    output SCHED_BURST_END,
    output SCHED_COUNT,
    output SCHED_OVERFLOW
  );

endinterface : spike_scheduler_if
`default_nettype wire

// File: rtl/spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spike_scheduler
// Description : Spike event FIFO with burst replication. Every spiking neuron
//               write-back pushes {burst-1, address}; the head entry is then
//               presented burst times (1..8) before being removed. A sticky
//               overflow flag records dropped events, and the activity gate
//               flushes the whole queue synchronously.
// Ports       : CLK         - single clock, rising-edge state updates
//               RSTN_syncn  - asynchronous active-low reset
//               sched       - spike_scheduler_if.slave bundle (see interface)
// Revision    : 1.0 - initial release
// ============================================================================
module spike_scheduler #(
  parameter int N     = 256,  // number of neurons
  parameter int M     = 8,    // neuron address width, log2(N)
  parameter int DEPTH = 16    // FIFO entries, power of two, >= 2
) (
  input  wire logic          CLK,
  input  wire logic          RSTN_syncn,
  spike_scheduler_if.slave   sched
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              c_AW        = $clog2(DEPTH);
  localparam int              c_EW        = M + 3;           // burst + address
  localparam logic [c_AW:0]   c_CNT_FULL  = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE   = c_AW'(1);

  // N is carried implicitly through M; it only documents the neuron space.
  localparam int              c_unused_n  = N;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic [2:0]      r_rcnt;
  logic            r_overflow;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic            w_gate;
  logic            w_empty;
  logic            w_full;
  logic [c_EW-1:0] w_head;
  logic [2:0]      w_head_burst;
  logic            w_burst_end;
  logic            w_pop_valid;
  logic            w_deq;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic [c_EW-1:0] w_entry;
  logic            w_unused_rsvd;

  assign w_gate       = sched.SPI_GATE_ACTIVITY_sync;
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == c_CNT_FULL);

  // Head is read asynchronously so a push into an empty queue is visible
  // right after the write edge.
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_burst = w_head[c_EW-1:M];
  assign w_burst_end  = !w_empty && (r_rcnt == w_head_burst);

  // A pop on an empty queue, or while gated, is a no-op.
  assign w_pop_valid  = sched.CTRL_SCHED_POP && !w_gate && !w_empty;
  assign w_deq        = w_pop_valid && w_burst_end;

  assign w_push_req   = sched.CTRL_NEURMEM_CS && sched.CTRL_NEURMEM_WE &&
                        sched.NEUR_EVENT_OUT[6] && !w_gate;
  // When full, the slot freed by a same-cycle dequeue is reused: wr_ptr equals
  // rd_ptr then, and the old head has already been presented this cycle.
  assign w_push       = w_push_req && (!w_full || w_deq);
  assign w_drop       = w_push_req && w_full && !w_deq;

  assign w_entry      = {sched.NEUR_EVENT_OUT[2:0], sched.CTRL_NEURMEM_ADDR};

  // Reserved event bits carry no meaning here.
  assign w_unused_rsvd = ^sched.NEUR_EVENT_OUT[5:3];

  // --------------------------------------------------------------------------
  // Storage: no reset needed, validity is tracked by the pointers and count.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, replica counter and overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN_syncn) begin
    if (!RSTN_syncn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rcnt     <= '0;
      r_overflow <= 1'b0;
    end else if (w_gate) begin
      // Flush: the whole queue and its bookkeeping are discarded.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        r_rcnt   <= '0;
      end else if (w_pop_valid) begin
        r_rcnt   <= r_rcnt + 3'd1;
      end

      unique case ({w_push, w_deq})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sched.SCHED_EMPTY     = w_empty;
  assign sched.SCHED_FULL      = w_full;
  assign sched.SCHED_DATA_OUT  = w_empty ? '0 : w_head[M-1:0];
  assign sched.SCHED_BURST_END = w_burst_end;
  assign sched.SCHED_COUNT     = r_count;
  assign sched.SCHED_OVERFLOW  = r_overflow;

endmodule : spike_scheduler
`default_nettype wire

// File: tb/tb_spike_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_scheduler
// Description : Directed self-checking bench for spike_scheduler. Inputs are
//               driven one time unit after each rising edge; outputs are
//               compared at that same point, after the state has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_scheduler;

  localparam int c_M     = 8;
  localparam int c_DEPTH = 16;

  logic CLK;
  logic RSTN_syncn;
  int   errors;
  int   checks;

  spike_scheduler_if #(.M(c_M), .DEPTH(c_DEPTH)) sif ();

  spike_scheduler #(.N(256), .M(c_M), .DEPTH(c_DEPTH)) dut (
    .CLK        (CLK),
    .RSTN_syncn (RSTN_syncn),
    .sched      (sif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] addr, input logic [2:0] burst);
    sif.CTRL_NEURMEM_CS   = 1'b1;
    sif.CTRL_NEURMEM_WE   = 1'b1;
    sif.CTRL_NEURMEM_ADDR = addr;
    sif.NEUR_EVENT_OUT    = {1'b1, 3'b101, burst};  // reserved bits deliberately set
    tick();
    sif.CTRL_NEURMEM_CS   = 1'b0;
    sif.CTRL_NEURMEM_WE   = 1'b0;
    sif.NEUR_EVENT_OUT    = 7'd0;
  endtask

  task automatic pop();
    sif.CTRL_SCHED_POP = 1'b1;
    tick();
    sif.CTRL_SCHED_POP = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RSTN_syncn                 = 1'b0;
    sif.SPI_GATE_ACTIVITY_sync = 1'b0;
    sif.CTRL_NEURMEM_CS        = 1'b0;
    sif.CTRL_NEURMEM_WE        = 1'b0;
    sif.CTRL_NEURMEM_ADDR      = '0;
    sif.NEUR_EVENT_OUT         = '0;
    sif.CTRL_SCHED_POP         = 1'b0;

    // ---- reset values ----
    #2;
    chk("rst_empty",   32'(sif.SCHED_EMPTY),     32'd1);
    chk("rst_full",    32'(sif.SCHED_FULL),      32'd0);
    chk("rst_data",    32'(sif.SCHED_DATA_OUT),  32'd0);
    chk("rst_bend",    32'(sif.SCHED_BURST_END), 32'd0);
    chk("rst_count",   32'(sif.SCHED_COUNT),     32'd0);
    chk("rst_ovf",     32'(sif.SCHED_OVERFLOW),  32'd0);
    tick();
    tick();
    RSTN_syncn = 1'b1;
    tick();

    // ---- single event, burst 0 ----
    push(8'h2A, 3'd0);
    chk("b0_data",     32'(sif.SCHED_DATA_OUT),  32'h2A);
    chk("b0_bend",     32'(sif.SCHED_BURST_END), 32'd1);
    chk("b0_count",    32'(sif.SCHED_COUNT),     32'd1);
    chk("b0_empty",    32'(sif.SCHED_EMPTY),     32'd0);
    pop();
    chk("b0_empty2",   32'(sif.SCHED_EMPTY),     32'd1);
    chk("b0_data0",    32'(sif.SCHED_DATA_OUT),  32'd0);

    // ---- pop while empty is ignored ----
    pop();
    chk("epop_count",  32'(sif.SCHED_COUNT),     32'd0);
    chk("epop_empty",  32'(sif.SCHED_EMPTY),     32'd1);

    // ---- burst of 4 replicas ----
    push(8'h05, 3'd3);
    chk("b3_data",     32'(sif.SCHED_DATA_OUT),  32'h05);
    chk("b3_bend_p1",  32'(sif.SCHED_BURST_END), 32'd0);
    pop();
    chk("b3_bend_p2",  32'(sif.SCHED_BURST_END), 32'd0);
    chk("b3_data_p2",  32'(sif.SCHED_DATA_OUT),  32'h05);
    pop();
    chk("b3_bend_p3",  32'(sif.SCHED_BURST_END), 32'd0);
    pop();
    chk("b3_bend_p4",  32'(sif.SCHED_BURST_END), 32'd1);
    chk("b3_count_p4", 32'(sif.SCHED_COUNT),     32'd1);
    pop();
    chk("b3_empty",    32'(sif.SCHED_EMPTY),     32'd1);

    // ---- fill to 16, then overflow ----
    for (int i = 0; i < 16; i++) push(8'(i), 3'd0);
    chk("fill_count",  32'(sif.SCHED_COUNT),     32'd16);
    chk("fill_full",   32'(sif.SCHED_FULL),      32'd1);
    chk("fill_ovf",    32'(sif.SCHED_OVERFLOW),  32'd0);
    push(8'h99, 3'd0);
    chk("ovf_full",    32'(sif.SCHED_FULL),      32'd1);
    chk("ovf_flag",    32'(sif.SCHED_OVERFLOW),  32'd1);
    chk("ovf_count",   32'(sif.SCHED_COUNT),     32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(sif.SCHED_DATA_OUT), 32'(i));
      pop();
    end
    chk("drain_empty", 32'(sif.SCHED_EMPTY),     32'd1);
    chk("ovf_sticky",  32'(sif.SCHED_OVERFLOW),  32'd1);

    // flush clears the sticky flag
    sif.SPI_GATE_ACTIVITY_sync = 1'b1;
    tick();
    sif.SPI_GATE_ACTIVITY_sync = 1'b0;
    chk("flush_ovf",   32'(sif.SCHED_OVERFLOW),  32'd0);

    // ---- full, simultaneous push and dequeue ----
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 3'd0);
    chk("sim_full",    32'(sif.SCHED_FULL),      32'd1);
    sif.CTRL_SCHED_POP = 1'b1;
    push(8'hAB, 3'd0);
    sif.CTRL_SCHED_POP = 1'b0;
    chk("sim_count",   32'(sif.SCHED_COUNT),     32'd16);
    chk("sim_ovf",     32'(sif.SCHED_OVERFLOW),  32'd0);
    chk("sim_head",    32'(sif.SCHED_DATA_OUT),  32'h11);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("sim_drain_%0d", i), 32'(sif.SCHED_DATA_OUT), 32'(8'h11 + i));
      pop();
    end
    chk("sim_last",    32'(sif.SCHED_DATA_OUT),  32'hAB);
    chk("sim_lastcnt", 32'(sif.SCHED_COUNT),     32'd1);
    pop();
    chk("sim_empty",   32'(sif.SCHED_EMPTY),     32'd1);

    // ---- flush while pushing ----
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 3'd1);
    chk("gate_pre",    32'(sif.SCHED_COUNT),     32'd5);
    sif.SPI_GATE_ACTIVITY_sync = 1'b1;
    push(8'h77, 3'd0);
    sif.SPI_GATE_ACTIVITY_sync = 1'b0;
    chk("gate_count",  32'(sif.SCHED_COUNT),     32'd0);
    chk("gate_empty",  32'(sif.SCHED_EMPTY),     32'd1);
    chk("gate_ovf",    32'(sif.SCHED_OVERFLOW),  32'd0);
    tick();
    chk("gate_count2", 32'(sif.SCHED_COUNT),     32'd0);
    chk("gate_data",   32'(sif.SCHED_DATA_OUT),  32'd0);

    // ---- asynchronous reset mid-burst ----
    push(8'h33, 3'd4);
    pop();
    pop();
    chk("mid_bend",    32'(sif.SCHED_BURST_END), 32'd0);
    chk("mid_data",    32'(sif.SCHED_DATA_OUT),  32'h33);
    #2;
    RSTN_syncn = 1'b0;
    #1;
    chk("arst_empty",  32'(sif.SCHED_EMPTY),     32'd1);
    chk("arst_count",  32'(sif.SCHED_COUNT),     32'd0);
    chk("arst_data",   32'(sif.SCHED_DATA_OUT),  32'd0);
    chk("arst_bend",   32'(sif.SCHED_BURST_END), 32'd0);
    chk("arst_full",   32'(sif.SCHED_FULL),      32'd0);
    #2;
    RSTN_syncn = 1'b1;
    tick();
    push(8'h44, 3'd0);
    chk("post_data",   32'(sif.SCHED_DATA_OUT),  32'h44);
    chk("post_bend",   32'(sif.SCHED_BURST_END), 32'd1);
    chk("post_count",  32'(sif.SCHED_COUNT),     32'd1);
    pop();
    chk("post_empty",  32'(sif.SCHED_EMPTY),     32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_spike_scheduler
`default_nettype wire
